game_flow_ctrl: RTL and testbench
=================================

# game_flow_ctrl

Top-level game sequencer driving the per-level claw/loot FSM from the other side of its level interface. It launches each level with a single `start_level` pulse and presents that level's `goal`. It runs the level countdown and raises `timer_ended`, then waits for `level_ended` and judges the level score on Enter: advance, win, or game over. It also keeps the running total score and the level number for the HUD.

## Interface
- `NUM_LEVELS`, 4: levels per game (1..8).
- `LEVEL_SECONDS`, 60: countdown per level (1..127).
- `FRAMES_PER_SEC`, 30: `startOfFrame` pulses per second (2..63).
- `GOAL_BASE`, 10'd20: goal of level 0.
- `GOAL_STEP`, 10'd20: goal increment per level.
- `clk` in 1: system clock.
- `resetN` in 1: asynchronous, active-low reset.
- `startOfFrame` in 1: one-clock pulse at frame start.
- `is_enter_pressed` in 1: one-clock pulse per Enter press.
- `pause_key` in 1: one-clock pulse; used only with `GAME_PAUSE_EN`.
- `level_ended` in 1: from the level FSM; held high while that FSM is in its end state.
- `level_score` in 10: level FSM score; valid while `level_ended`=1.
- `start_level` out 1: one-clock launch pulse.
- `goal` out 10: current level goal.
- `timer_ended` out 1: level time expired.
- `time_left` out 7: seconds remaining.
- `level_num` out 3: current level, 0-based.
- `total_score` out 14: accumulated score.
- `game_over` out 1: game lost, held.
- `game_won` out 1: all levels passed, held.
- `paused` out 1: countdown frozen.

## Operation
- States: TITLE_ST, LAUNCH_ST, PLAY_ST, WAIT_END_ST, RESULT_ST, OVER_ST, WON_ST.
- TITLE_ST:
  - Clears `level_num` and `total_score`.
  - On `is_enter_pressed`, goes to LAUNCH_ST.
- LAUNCH_ST:
  - Loads `goal`=GOAL_BASE+`level_num`*GOAL_STEP (10-bit, wraps) and `time_left`=LEVEL_SECONDS.
  - Clears `timer_ended`, the frame counter and `paused`.
  - Waits for `level_ended`=0, then pulses `start_level` for one clock and goes to PLAY_ST.
- PLAY_ST:
  - Each `startOfFrame` (while not `paused`) increments a 6-bit frame counter.
  - At FRAMES_PER_SEC-1 the counter wraps to 0 and `time_left` decrements.
  - When the decrement yields 0, `timer_ended`<=1 in the same clock and the state goes to WAIT_END_ST.
- WAIT_END_ST:
  - `timer_ended` is held.
  - On `level_ended`=1, latches `level_score` and adds it to `total_score`, saturating at 16383.
  - Goes to RESULT_ST.
- RESULT_ST, on `is_enter_pressed`:
  - Latched score >= `goal` and `level_num`=NUM_LEVELS-1: go to WON_ST.
  - Latched score >= `goal`, otherwise: `level_num`++ and go to LAUNCH_ST.
  - Latched score < `goal`: go to OVER_ST.
- OVER_ST / WON_ST:
  - Hold `game_over` / `game_won`=1.
  - `is_enter_pressed` clears the flag and returns to TITLE_ST.
- Illegal state: go to TITLE_ST.
- `level_ended` rising while in PLAY_ST is ignored; the countdown is authoritative.

## Timing
- Reset values: every output 0, state TITLE_ST, frame counter 0.
- Reset is honoured mid-level; no pulse of `start_level` is emitted on reset exit.
- `start_level` is exactly one clock wide, registered, and issued only when `level_ended`=0 and `timer_ended`=0.
- `startOfFrame` coinciding with the PLAY_ST entry clock is not counted.
- Enter in the same clock as the WAIT_END_ST to RESULT_ST transition is ignored; RESULT_ST needs a fresh pulse.
- Time per level: LEVEL_SECONDS*FRAMES_PER_SEC counted frames from the `start_level` clock to `timer_ended`.

## Configuration
- `GAME_PAUSE_EN` defined:
  - In PLAY_ST, `pause_key` toggles `paused`.
  - While paused, the frame counter and `time_left` hold.
  - `paused` clears in LAUNCH_ST and on any exit from PLAY_ST.
- `GAME_PAUSE_EN` undefined: `pause_key` is ignored and `paused` is tied to 0.

## Test plan
- Sim params NUM_LEVELS=2, LEVEL_SECONDS=3, FRAMES_PER_SEC=2, GOAL_BASE=20, GOAL_STEP=20.
- Reset, then Enter -> one `start_level` pulse, `goal`=20, `time_left`=3; after 6 `startOfFrame` pulses, `timer_ended`=1 and `time_left`=0.
- Level 0: `level_ended`=1 with `level_score`=25, then Enter -> `total_score`=25, `level_num`=1. Drop `level_ended`, then one `start_level` pulse with `goal`=40.
- Level 1 with score 40 and Enter -> `game_won`=1, `total_score`=65. Next Enter -> TITLE_ST, all outputs 0.
- Level 0 with score 19 and Enter -> `game_over`=1, `total_score`=19, no `start_level` pulse.
- Hold `level_ended`=1 through the Enter in RESULT_ST -> `start_level` stays 0 until `level_ended` falls, then pulses exactly once.
- `GAME_PAUSE_EN`: `pause_key` after 2 frames, 10 frames, `pause_key` -> `time_left` stays 2 while paused. Assert `resetN` mid-pause -> all outputs 0 immediately.

Source files
------------

// File: rtl/game_flow_ctrl.sv
`default_nettype none
// ============================================================================
// Module      : game_flow_ctrl
// Description : Top-level game sequencer. Launches each level of the claw/loot
//               level FSM with a one-clock start_level pulse and presents the
//               level goal. Runs the per-level countdown from startOfFrame
//               pulses, raises timer_ended, then waits for level_ended and
//               judges the latched level score on Enter (advance, win or game
//               over). Keeps the saturating total score and level number for
//               the HUD.
//
// Optional feature macro : GAME_PAUSE_EN
//               defined   -> pause_key toggles paused in PLAY_ST and freezes
//                            the countdown
//               undefined -> pause_key ignored, paused tied to 0
//
// Ports
//   clk              in   system clock
//   resetN           in   asynchronous active-low reset
//   startOfFrame     in   one-clock pulse at frame start
//   is_enter_pressed in   one-clock pulse per Enter press
//   pause_key        in   one-clock pause toggle (GAME_PAUSE_EN only)
//   level_ended      in   level FSM is in its end state
//   level_score[9:0] in   level FSM score, valid while level_ended=1
//   start_level      out  one-clock level launch pulse
//   goal[9:0]        out  current level goal
//   timer_ended      out  level time expired
//   time_left[6:0]   out  seconds remaining
//   level_num[2:0]   out  current level, 0-based
//   total_score[13:0]out  accumulated score (saturating)
//   game_over        out  game lost (held)
//   game_won         out  all levels passed (held)
//   paused           out  countdown frozen
//
// Revision    : 1.0 - initial release
// ============================================================================
module game_flow_ctrl #(
    parameter int         NUM_LEVELS     = 4,
    parameter int         LEVEL_SECONDS  = 60,
    parameter int         FRAMES_PER_SEC = 30,
    parameter logic [9:0] GOAL_BASE      = 10'd20,
    parameter logic [9:0] GOAL_STEP      = 10'd20
) (
    input  logic        clk,
    input  logic        resetN,
    input  logic        startOfFrame,
    input  logic        is_enter_pressed,
    input  logic        pause_key,
    input  logic        level_ended,
    input  logic [9:0]  level_score,
    output logic        start_level,
    output logic [9:0]  goal,
    output logic        timer_ended,
    output logic [6:0]  time_left,
    output logic [2:0]  level_num,
    output logic [13:0] total_score,
    output logic        game_over,
    output logic        game_won,
    output logic        paused
);

    typedef enum logic [2:0] {
        TITLE_ST    = 3'd0,
        LAUNCH_ST   = 3'd1,
        PLAY_ST     = 3'd2,
        WAIT_END_ST = 3'd3,
        RESULT_ST   = 3'd4,
        OVER_ST     = 3'd5,
        WON_ST      = 3'd6
    } state_t;

    localparam logic [5:0]  c_frame_last = 6'(FRAMES_PER_SEC - 1);
    localparam logic [6:0]  c_time_init  = 7'(LEVEL_SECONDS);
    localparam logic [2:0]  c_last_level = 3'(NUM_LEVELS - 1);
    localparam logic [14:0] c_score_max  = 15'd16383;

    state_t        state_q, state_d;
    logic [2:0]    level_num_q, level_num_d;
    logic [13:0]   total_score_q, total_score_d;
    logic [9:0]    goal_q, goal_d;
    logic [6:0]    time_left_q, time_left_d;
    logic          timer_ended_q, timer_ended_d;
    logic [5:0]    frame_cnt_q, frame_cnt_d;
    logic          paused_q, paused_d;
    logic          start_level_q, start_level_d;
    logic [9:0]    score_q, score_d;
    logic          game_over_q, game_over_d;
    logic          game_won_q, game_won_d;
    logic          clear_all;

    logic [9:0]    w_goal_calc;
    logic [14:0]   w_score_sum;
    logic          w_frame_en;

    // Goal arithmetic is 10-bit and wraps by design.
    assign w_goal_calc = GOAL_BASE + 10'(level_num_q) * GOAL_STEP;
    assign w_score_sum = {1'b0, total_score_q} + {5'd0, level_score};
    // The frame arriving in the PLAY_ST entry clock (start_level still high)
    // is not counted, so each level sees exactly LEVEL_SECONDS*FRAMES_PER_SEC
    // counted frames after the launch pulse.
    assign w_frame_en  = startOfFrame && !paused_q && !start_level_q;

`ifndef GAME_PAUSE_EN
    logic w_unused_pause;
    assign w_unused_pause = pause_key;
`endif

    always_comb begin
        state_d       = state_q;
        level_num_d   = level_num_q;
        total_score_d = total_score_q;
        goal_d        = goal_q;
        time_left_d   = time_left_q;
        timer_ended_d = timer_ended_q;
        frame_cnt_d   = frame_cnt_q;
        paused_d      = 1'b0;
        start_level_d = 1'b0;
        score_d       = score_q;
        game_over_d   = game_over_q;
        game_won_d    = game_won_q;
        clear_all     = 1'b0;

        case (state_q)
            TITLE_ST: begin
                clear_all = 1'b1;
                if (is_enter_pressed) begin
                    state_d = LAUNCH_ST;
                end
            end

            LAUNCH_ST: begin
                goal_d        = w_goal_calc;
                time_left_d   = c_time_init;
                timer_ended_d = 1'b0;
                frame_cnt_d   = 6'd0;
                // timer_ended_q is still set on the first LAUNCH_ST clock after
                // a level, so the launch naturally slips by one clock there.
                if (!level_ended && !timer_ended_q) begin
                    start_level_d = 1'b1;
                    state_d       = PLAY_ST;
                end
            end

            PLAY_ST: begin
`ifdef GAME_PAUSE_EN
                paused_d = paused_q ^ pause_key;
`endif
                if (w_frame_en) begin
                    if (frame_cnt_q == c_frame_last) begin
                        frame_cnt_d = 6'd0;
                        time_left_d = time_left_q - 7'd1;
                        if (time_left_q == 7'd1) begin
                            timer_ended_d = 1'b1;
                            paused_d      = 1'b0;
                            state_d       = WAIT_END_ST;
                        end
                    end else begin
                        frame_cnt_d = frame_cnt_q + 6'd1;
                    end
                end
            end

            WAIT_END_ST: begin
                if (level_ended) begin
                    score_d       = level_score;
                    total_score_d = (w_score_sum > c_score_max) ?
                                    c_score_max[13:0] : w_score_sum[13:0];
                    state_d       = RESULT_ST;
                end
            end

            RESULT_ST: begin
                if (is_enter_pressed) begin
                    if (score_q >= goal_q) begin
                        if (level_num_q == c_last_level) begin
                            game_won_d = 1'b1;
                            state_d    = WON_ST;
                        end else begin
                            level_num_d = level_num_q + 3'd1;
                            state_d     = LAUNCH_ST;
                        end
                    end else begin
                        game_over_d = 1'b1;
                        state_d     = OVER_ST;
                    end
                end
            end

            OVER_ST, WON_ST: begin
                // Leaving the end screen clears the HUD in the same clock so
                // the title screen shows all zeros immediately.
                if (is_enter_pressed) begin
                    clear_all = 1'b1;
                    state_d   = TITLE_ST;
                end
            end

            default: begin
                state_d = TITLE_ST;
            end
        endcase

        if (clear_all) begin
            level_num_d   = 3'd0;
            total_score_d = 14'd0;
            goal_d        = 10'd0;
            time_left_d   = 7'd0;
            timer_ended_d = 1'b0;
            frame_cnt_d   = 6'd0;
            score_d       = 10'd0;
            game_over_d   = 1'b0;
            game_won_d    = 1'b0;
        end
    end

    always_ff @(posedge clk or negedge resetN) begin
        if (!resetN) begin
            state_q       <= TITLE_ST;
            level_num_q   <= 3'd0;
            total_score_q <= 14'd0;
            goal_q        <= 10'd0;
            time_left_q   <= 7'd0;
            timer_ended_q <= 1'b0;
            frame_cnt_q   <= 6'd0;
            paused_q      <= 1'b0;
            start_level_q <= 1'b0;
            score_q       <= 10'd0;
            game_over_q   <= 1'b0;
            game_won_q    <= 1'b0;
        end else begin
            state_q       <= state_d;
            level_num_q   <= level_num_d;
            total_score_q <= total_score_d;
            goal_q        <= goal_d;
            time_left_q   <= time_left_d;
            timer_ended_q <= timer_ended_d;
            frame_cnt_q   <= frame_cnt_d;
            paused_q      <= paused_d;
            start_level_q <= start_level_d;
            score_q       <= score_d;
            game_over_q   <= game_over_d;
            game_won_q    <= game_won_d;
        end
    end

    assign start_level = start_level_q;
    assign goal        = goal_q;
    assign timer_ended = timer_ended_q;
    assign time_left   = time_left_q;
    assign level_num   = level_num_q;
    assign total_score = total_score_q;
    assign game_over   = game_over_q;
    assign game_won    = game_won_q;
    assign paused      = paused_q;

endmodule
`default_nettype wire

// File: tb/tb_game_flow_ctrl.sv
`default_nettype none
// ============================================================================
// Module      : tb_game_flow_ctrl
// Description : Self-checking bench for game_flow_ctrl. Directed game flows
//               plus randomized games (scores, frame gaps, end-state delays)
//               checked against a behavioural model of level number, total
//               score, goals and remaining seconds.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_game_flow_ctrl;

    localparam int NL  = 2;
    localparam int LS  = 3;
    localparam int FPS = 2;
    localparam int GB  = 20;
    localparam int GS  = 20;

    logic        clk = 1'b0;
    logic        resetN = 1'b0;
    logic        startOfFrame = 1'b0;
    logic        is_enter_pressed = 1'b0;
    logic        pause_key = 1'b0;
    logic        level_ended = 1'b0;
    logic [9:0]  level_score = 10'd0;
    logic        start_level;
    logic [9:0]  goal;
    logic        timer_ended;
    logic [6:0]  time_left;
    logic [2:0]  level_num;
    logic [13:0] total_score;
    logic        game_over;
    logic        game_won;
    logic        paused;

    int n_cmp = 0;
    int n_err = 0;
    int m_lvl = 0;
    int m_total = 0;
    int outcome;
    int score;
    int gl;
    bit pass;

    game_flow_ctrl #(
        .NUM_LEVELS    (NL),
        .LEVEL_SECONDS (LS),
        .FRAMES_PER_SEC(FPS),
        .GOAL_BASE     (10'd20),
        .GOAL_STEP     (10'd20)
    ) dut (
        .clk             (clk),
        .resetN          (resetN),
        .startOfFrame    (startOfFrame),
        .is_enter_pressed(is_enter_pressed),
        .pause_key       (pause_key),
        .level_ended     (level_ended),
        .level_score     (level_score),
        .start_level     (start_level),
        .goal            (goal),
        .timer_ended     (timer_ended),
        .time_left       (time_left),
        .level_num       (level_num),
        .total_score     (total_score),
        .game_over       (game_over),
        .game_won        (game_won),
        .paused          (paused)
    );

    always #5 clk = ~clk;

    initial begin
        #2000000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    function automatic int goal_of(input int l);
        return (GB + l * GS) % 1024;
    endfunction

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_cmp++;
        assert (obs === exp) else begin
            n_err++;
            $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
        end
    endtask

    task automatic enter();
        is_enter_pressed = 1'b1;
        tick();
        is_enter_pressed = 1'b0;
    endtask

    task automatic frame();
        startOfFrame = 1'b1;
        tick();
        startOfFrame = 1'b0;
    endtask

    task automatic check_zero();
        chk("z_start_level", 32'(start_level), 0);
        chk("z_goal",        32'(goal), 0);
        chk("z_timer_ended", 32'(timer_ended), 0);
        chk("z_time_left",   32'(time_left), 0);
        chk("z_level_num",   32'(level_num), 0);
        chk("z_total_score", 32'(total_score), 0);
        chk("z_game_over",   32'(game_over), 0);
        chk("z_game_won",    32'(game_won), 0);
        chk("z_paused",      32'(paused), 0);
    endtask

    // Waits (bounded) for the launch pulse, then checks it is one clock wide.
    task automatic wait_start();
        bit seen = 1'b0;
        for (int i = 0; i < 20; i++) begin
            if (start_level === 1'b1) begin
                seen = 1'b1;
                break;
            end
            tick();
        end
        chk("start_pulse_seen", 32'(seen), 1);
        tick();
        chk("start_pulse_width", 32'(start_level), 0);
    endtask

    // Plays one launched level to its judged result.
    // outcome: 0 advance, 1 won, 2 over. level_ended is left high.
    task automatic run_level(input int sc, output int res);
        int k_tot = LS * FPS;
        int spur  = int'($urandom_range(1, k_tot - 1));
        chk("goal",        32'(goal), 32'(goal_of(m_lvl)));
        chk("time_init",   32'(time_left), 32'(LS));
        chk("level_num",   32'(level_num), 32'(m_lvl));
        chk("timer_start", 32'(timer_ended), 0);
        for (int k = 1; k <= k_tot; k++) begin
            if (k == spur) level_ended = 1'b1;   // must be ignored while playing
            frame();
            level_ended = 1'b0;
            chk("time_left",   32'(time_left), 32'(LS - k / FPS));
            chk("timer_ended", 32'(timer_ended), (k == k_tot) ? 1 : 0);
            repeat ($urandom_range(0, 2)) tick();
        end
        repeat ($urandom_range(0, 3)) begin
            tick();
            chk("timer_hold", 32'(timer_ended), 1);
        end
        // Enter together with the end report must be ignored.
        level_ended      = 1'b1;
        level_score      = 10'(sc);
        is_enter_pressed = 1'b1;
        tick();
        is_enter_pressed = 1'b0;
        m_total = (m_total + sc > 16383) ? 16383 : m_total + sc;
        chk("total_latched", 32'(total_score), 32'(m_total));
        tick();
        chk("stale_enter_won",  32'(game_won), 0);
        chk("stale_enter_over", 32'(game_over), 0);
        chk("stale_enter_lvl",  32'(level_num), 32'(m_lvl));
        enter();
        if (sc >= goal_of(m_lvl)) begin
            if (m_lvl == NL - 1) begin
                res = 1;
                chk("won_flag",  32'(game_won), 1);
                chk("won_over",  32'(game_over), 0);
            end else begin
                res = 0;
                m_lvl++;
                chk("advance_lvl",  32'(level_num), 32'(m_lvl));
                chk("advance_won",  32'(game_won), 0);
            end
        end else begin
            res = 2;
            chk("over_flag", 32'(game_over), 1);
            chk("over_won",  32'(game_won), 0);
        end
        chk("result_no_start", 32'(start_level), 0);
        chk("result_total",    32'(total_score), 32'(m_total));
    endtask

    // Holds level_ended a while (no launch allowed), then drops it.
    task automatic release_and_start();
        repeat ($urandom_range(0, 4)) begin
            tick();
            chk("start_held_off", 32'(start_level), 0);
        end
        level_ended = 1'b0;
        wait_start();
    endtask

    task automatic end_game();
        level_ended = 1'b0;
        repeat (3) begin
            tick();
            chk("end_no_start", 32'(start_level), 0);
        end
        enter();
        m_lvl   = 0;
        m_total = 0;
        check_zero();
    endtask

    initial begin
        resetN = 1'b0;
        repeat (3) tick();
        check_zero();
        resetN = 1'b1;
        repeat (3) begin
            tick();
            chk("idle_no_start", 32'(start_level), 0);
        end

        // Game 1: pass level 0 with 25, win level 1 with 40.
        enter();
        wait_start();
        run_level(25, outcome);
        release_and_start();
        run_level(40, outcome);
        chk("won_total", 32'(total_score), 65);
        end_game();

        // Game 2: fail level 0 with 19.
        enter();
        wait_start();
        run_level(19, outcome);
        chk("over_total", 32'(total_score), 19);
        end_game();

        // Randomized games.
        for (int g = 0; g < 4; g++) begin
            enter();
            wait_start();
            outcome = 0;
            while (outcome == 0) begin
                pass  = ($urandom_range(0, 3) != 0);
                gl    = goal_of(m_lvl);
                score = pass ? gl + int'($urandom_range(0, 200))
                             : int'($urandom_range(0, gl - 1));
                run_level(score, outcome);
                if (outcome == 0) release_and_start();
            end
            end_game();
        end

        // Pause behaviour, then reset in the middle of a level.
        enter();
        wait_start();
        frame();
        frame();
        chk("pre_pause_time", 32'(time_left), 2);
`ifdef GAME_PAUSE_EN
        pause_key = 1'b1;
        tick();
        pause_key = 1'b0;
        chk("paused_set", 32'(paused), 1);
        repeat (10) frame();
        chk("paused_time",  32'(time_left), 2);
        chk("paused_hold",  32'(paused), 1);
        chk("paused_timer", 32'(timer_ended), 0);
`else
        pause_key = 1'b1;
        tick();
        pause_key = 1'b0;
        chk("pause_ignored", 32'(paused), 0);
        frame();
        frame();
        chk("nopause_time", 32'(time_left), 1);
`endif
        resetN = 1'b0;
        #1;
        check_zero();
        tick();
        resetN = 1'b1;
        repeat (4) begin
            tick();
            chk("post_reset_no_start", 32'(start_level), 0);
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
`default_nettype wire
